// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin arbiter that lets four requesters share one
// pipelined fp16 multiplier. Operands are registered to the multiplier; the
// product is captured after LAT+1 wait cycles and held until it is accepted.
module fp16_mul_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_id,
    output logic        busy,
    output logic [7:0]  done_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    logic [1:0]  state_q,    state_d;
    logic [1:0]  ptr_q,      ptr_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [15:0] mul_a_q,    mul_a_d;
    logic [15:0] mul_b_q,    mul_b_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_id_q,   rsp_id_d;
    logic [7:0]  done_cnt_q, done_cnt_d;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  scan_idx;
    logic        accept;

    // Round-robin search: first requesting slot at or above ptr, wrapping mod 4
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            scan_idx = ptr_q + 2'(j);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Grants and status are masked while reset is held so nothing leaks out
    always_comb begin
        accept    = RESETn && (state_q == S_IDLE) && grant_vld;
        req_ready = accept ? (4'b0001 << grant_idx) : '0;
        rsp_valid = RESETn && (state_q == S_RESP);
        busy      = RESETn && (state_q != S_IDLE);
    end

    // Next-state logic for the IDLE -> WAIT -> RESP operation sequence
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mul_a_d  = req_a[{grant_idx, 4'b0000} +: 16];
                    mul_b_d  = req_b[{grant_idx, 4'b0000} +: 16];
                    rsp_id_d = grant_idx;
                    cnt_d    = LAT_CNT;
                    ptr_d    = grant_idx + 2'd1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = mul_out;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Bench for fp16_mul_arbiter: two instances (LAT=1 and LAT=4), each fed by a
// behavioural fp16 multiplier pipeline. Directed table, hand sequences for
// round robin / reset / drop, and random ops checked against a reference model.
module tb_fp16_mul_arbiter;

    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn_s    [2];
    logic [3:0]  req_valid_s [2];
    logic [3:0]  req_ready_s [2];
    logic [63:0] req_a_s     [2];
    logic [63:0] req_b_s     [2];
    logic [15:0] mul_a_s     [2];
    logic [15:0] mul_b_s     [2];
    logic [15:0] mul_out_s   [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [15:0] rsp_data_s  [2];
    logic [1:0]  rsp_id_s    [2];
    logic        busy_s      [2];
    logic [7:0]  done_s      [2];

    fp16_mul_arbiter #(.LAT(LAT0)) dut0 (
        .CLK(clk), .RESETn(resetn_s[0]), .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
        .req_a(req_a_s[0]), .req_b(req_b_s[0]), .mul_a(mul_a_s[0]), .mul_b(mul_b_s[0]),
        .mul_out(mul_out_s[0]), .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_data(rsp_data_s[0]), .rsp_id(rsp_id_s[0]), .busy(busy_s[0]), .done_cnt(done_s[0])
    );

    fp16_mul_arbiter #(.LAT(LAT1)) dut1 (
        .CLK(clk), .RESETn(resetn_s[1]), .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
        .req_a(req_a_s[1]), .req_b(req_b_s[1]), .mul_a(mul_a_s[1]), .mul_b(mul_b_s[1]),
        .mul_out(mul_out_s[1]), .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_data(rsp_data_s[1]), .rsp_id(rsp_id_s[1]), .busy(busy_s[1]), .done_cnt(done_s[1])
    );

    // Simple fp16 multiply (normals only, truncating; zero/subnormal -> 0, overflow -> inf)
    function automatic logic [15:0] fpmul(input logic [15:0] a, input logic [15:0] b);
        int          ea, eb, e;
        logic [21:0] m;
        logic [9:0]  f;
        logic        s;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 0 || eb == 0) return {s, 15'h0000};
        m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = ea + eb - 15;
        if (m[21]) begin
            f = m[20:11];
            e = e + 1;
        end else begin
            f = m[19:10];
        end
        if (e <= 0)  return {s, 15'h0000};
        if (e >= 31) return {s, 5'h1f, 10'h000};
        return {s, 5'(e), f};
    endfunction

    // Multiplier pipelines with LAT0 / LAT1 register stages
    logic [15:0] pipe [2][16];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int s = 15; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
            pipe[k][0] <= fpmul(mul_a_s[k], mul_b_s[k]);
        end
    end
    assign mul_out_s[0] = pipe[0][LAT0-1];
    assign mul_out_s[1] = pipe[1][LAT1-1];

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m  [2];
    int done_m [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    function automatic logic [1:0] model_grant(input int p, input logic [3:0] v);
        for (int j = 0; j < 4; j++)
            if (v[(p + j) % 4]) return 2'((p + j) % 4);
        return 2'd0;
    endfunction

    task automatic do_reset(input int k);
        @(negedge clk);
        resetn_s[k]    = 1'b0;
        req_valid_s[k] = 4'hF;
        rsp_ready_s[k] = 1'b1;
        #1;
        chk("reset_outputs", {28'h0, req_ready_s[k], rsp_valid_s[k], busy_s[k]}, 32'h0);
        @(negedge clk);
        resetn_s[k]    = 1'b1;
        req_valid_s[k] = 4'h0;
        rsp_ready_s[k] = 1'b0;
        ptr_m[k]  = 0;
        done_m[k] = 0;
        chk("reset_mul", {mul_a_s[k], mul_b_s[k]}, 32'h0);
        chk("reset_rsp", {6'h0, rsp_id_s[k], rsp_data_s[k], done_s[k]}, 32'h0);
    endtask

    // One full operation from an IDLE cycle through the response handshake
    task automatic do_op(input int k, input logic [3:0] valid, input logic [63:0] av,
                         input logic [63:0] bv, input int delay,
                         input logic [1:0] exp_id, input logic [15:0] exp_data);
        int cyc;
        @(negedge clk);
        chk("idle_busy", {31'h0, busy_s[k]}, 32'h0);
        req_valid_s[k] = valid;
        req_a_s[k]     = av;
        req_b_s[k]     = bv;
        rsp_ready_s[k] = 1'($urandom_range(0, 1));
        #1;
        chk("grant", {28'h0, req_ready_s[k]}, {28'h0, 4'b0001 << exp_id});
        @(negedge clk);
        req_valid_s[k] = 4'($urandom);
        req_a_s[k]     = {$urandom, $urandom};
        req_b_s[k]     = {$urandom, $urandom};
        #1;
        chk("wait_ready_busy", {27'h0, req_ready_s[k], busy_s[k]}, 32'h1);
        chk("mul_operands", {mul_a_s[k], mul_b_s[k]}, {av[16*exp_id +: 16], bv[16*exp_id +: 16]});
        cyc = 1;
        while (!rsp_valid_s[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rsp_ready_s[k] = 1'($urandom_range(0, 1));
        end
        chk("resp_latency", cyc, lat_of(k) + 2);
        chk("resp_data_id", {14'h0, rsp_id_s[k], rsp_data_s[k]}, {14'h0, exp_id, exp_data});
        chk("mul_hold", {mul_a_s[k], mul_b_s[k]}, {av[16*exp_id +: 16], bv[16*exp_id +: 16]});
        for (int d = 0; d < delay; d++) begin
            rsp_ready_s[k] = 1'b0;
            @(negedge clk);
            chk("bp_hold", {8'h0, rsp_valid_s[k], busy_s[k], req_ready_s[k], rsp_id_s[k], rsp_data_s[k]},
                {8'h0, 1'b1, 1'b1, 4'h0, exp_id, exp_data});
            chk("bp_done", {24'h0, done_s[k]}, done_m[k]);
        end
        rsp_ready_s[k] = 1'b1;
        req_valid_s[k] = 4'h0;
        @(negedge clk);
        rsp_ready_s[k] = 1'b0;
        done_m[k] = (done_m[k] + 1) % 256;
        ptr_m[k]  = (int'(exp_id) + 1) % 4;
        chk("post_hs_idle", {30'h0, rsp_valid_s[k], busy_s[k]}, 32'h0);
        chk("done_cnt", {24'h0, done_s[k]}, done_m[k]);
    endtask

    task automatic rand_op(input int k, input int max_delay);
        logic [3:0]  v;
        logic [63:0] av, bv;
        logic [1:0]  id;
        v  = 4'($urandom_range(1, 15));
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) av[16*$urandom_range(0, 3) +: 16] = 16'h3C00;
        id = model_grant(ptr_m[k], v);
        do_op(k, v, av, bv, $urandom_range(0, max_delay), id, fpmul(av[16*id +: 16], bv[16*id +: 16]));
    endtask

    // All four requesting with rsp_ready high: ids must rotate, accepts evenly spaced
    task automatic round_robin(input int k);
        int ids[$];
        int acc[$];
        @(negedge clk);
        req_valid_s[k] = 4'hF;
        rsp_ready_s[k] = 1'b1;
        for (int c = 0; c < 80 && ids.size() < 5; c++) begin
            #1;
            if (req_ready_s[k] != 4'h0) acc.push_back(c);
            if (rsp_valid_s[k]) begin
                ids.push_back(int'(rsp_id_s[k]));
                if (ids.size() == 5) req_valid_s[k] = 4'h0;
            end
            @(negedge clk);
        end
        rsp_ready_s[k] = 1'b0;
        chk("rr_count", ids.size(), 5);
        for (int i = 0; i < ids.size(); i++) chk("rr_id", ids[i], (ptr_m[k] + i) % 4);
        for (int i = 1; i < acc.size() && i < 5; i++) chk("rr_spacing", acc[i] - acc[i-1], lat_of(k) + 3);
        ptr_m[k]  = (ptr_m[k] + 5) % 4;
        done_m[k] = (done_m[k] + 5) % 256;
        chk("rr_done", {24'h0, done_s[k]}, done_m[k]);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        int          delay;
        logic [1:0]  id;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [63:0] av, bv;
        logic        bad;
        for (int k = 0; k < 2; k++) begin
            resetn_s[k] = 1'b0; req_valid_s[k] = '0; rsp_ready_s[k] = 1'b0;
            req_a_s[k] = '0; req_b_s[k] = '0; ptr_m[k] = 0; done_m[k] = 0;
        end
        repeat (2) @(negedge clk);
        do_reset(0);

        // From reset ptr=0: expected grants follow the rotating pointer
        tbl[0] = '{4'b0001, 16'h3C00, 16'h4000, 0,  2'd0, 16'h4000};
        tbl[1] = '{4'b0001, 16'h4000, 16'h4200, 1,  2'd0, 16'h4600};
        tbl[2] = '{4'b1111, 16'hBC00, 16'h3C00, 10, 2'd1, 16'hBC00};
        tbl[3] = '{4'b1001, 16'h4400, 16'h3800, 0,  2'd3, 16'h4000};
        tbl[4] = '{4'b0110, 16'h4200, 16'h4200, 2,  2'd1, 16'h4880};
        tbl[5] = '{4'b0100, 16'h0000, 16'h4000, 0,  2'd2, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            av[16*tbl[i].id +: 16] = tbl[i].a;
            bv[16*tbl[i].id +: 16] = tbl[i].b;
            do_op(0, tbl[i].valid, av, bv, tbl[i].delay, tbl[i].id, tbl[i].data);
        end

        // Requester drops before the edge: no grant, no state change
        @(negedge clk);
        req_valid_s[0] = 4'b0100;
        #1 chk("drop_ready_seen", {28'h0, req_ready_s[0]}, 32'h4);
        #1 req_valid_s[0] = 4'b0000;
        #1 chk("drop_ready_gone", {28'h0, req_ready_s[0]}, 32'h0);
        @(negedge clk);
        chk("drop_no_busy", {31'h0, busy_s[0]}, 32'h0);

        do_reset(0);
        round_robin(0);

        // Reset during WAIT discards the operation
        @(negedge clk);
        req_valid_s[0] = 4'b0100;
        req_a_s[0] = {$urandom, $urandom};
        #1 chk("rmid_grant", {28'h0, req_ready_s[0]}, {28'h0, 4'b0001 << model_grant(ptr_m[0], 4'b0100)});
        @(negedge clk);
        req_valid_s[0] = 4'h0;
        resetn_s[0] = 1'b0;
        @(negedge clk);
        resetn_s[0] = 1'b1;
        ptr_m[0] = 0; done_m[0] = 0;
        bad = 1'b0;
        for (int c = 0; c < LAT0 + 4; c++) begin
            if (rsp_valid_s[0] || busy_s[0]) bad = 1'b1;
            @(negedge clk);
        end
        chk("rmid_no_rsp", {31'h0, bad}, 32'h0);
        chk("rmid_done", {24'h0, done_s[0]}, 32'h0);
        av = {$urandom, $urandom}; bv = {$urandom, $urandom};
        do_op(0, 4'hF, av, bv, 0, 2'd0, fpmul(av[15:0], bv[15:0]));

        for (int i = 0; i < 60; i++) rand_op(0, 3);

        // LAT=4 instance: random traffic through a full done_cnt wrap
        do_reset(1);
        round_robin(1);
        for (int i = 0; i < 251; i++) rand_op(1, 2);
        chk("done_wrap", {24'h0, done_s[1]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
